// File: rtl/alu_rr_sequencer_if.sv
// Bus bundle between the ALU sequencer and its environment: two request ports,
// the shared-ALU drive/return lines and the response channel.
interface alu_rr_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_opa;
    logic [DATA_W-1:0] req0_opb;
    logic [2:0]        req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_opa;
    logic [DATA_W-1:0] req1_opb;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] alu_opa;
    logic [DATA_W-1:0] alu_opb;
    logic [2:0]        alu_op;
    logic [15:0]       alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport master (
        input  req0_valid, req0_opa, req0_opb, req0_op,
        input  req1_valid, req1_opa, req1_opb, req1_op,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_opa, alu_opb, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count
    );

    modport slave (
        output req0_valid, req0_opa, req0_opb, req0_op,
        output req1_valid, req1_opa, req1_opb, req1_op,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_opa, alu_opb, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count
    );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters;
// holds ALU inputs for a settle window, then returns the captured result.
module alu_rr_sequencer #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_rr_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] OP_DIV      = 3'b010;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              grant_s;
    logic              accept_s;
    logic              capture_s;
    logic              release_s;
    logic              last_grant_r;
    logic [3:0]        settle_cnt_r;
    logic              div0_r;
    logic [DATA_W-1:0] sel_opa_s;
    logic [DATA_W-1:0] sel_opb_s;
    logic [2:0]        sel_op_s;
    logic [DATA_W-1:0] alu_opa_r;
    logic [DATA_W-1:0] alu_opb_r;
    logic [2:0]        alu_op_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [15:0]       rsp_data_r;
    logic              rsp_err_r;
    logic [CNT_W-1:0]  op_count_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration, next-state and per-cycle strobes
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        // On a tie the port that did not win last time gets the grant
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (settle_cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand mux from the granted port
    always_comb begin
        sel_opa_s = bus.req0_opa;
        sel_opb_s = bus.req0_opb;
        sel_op_s  = bus.req0_op;
        if (grant_s) begin
            sel_opa_s = bus.req1_opa;
            sel_opb_s = bus.req1_opb;
            sel_op_s  = bus.req1_op;
        end else begin
            sel_opa_s = bus.req0_opa;
            sel_opb_s = bus.req0_opb;
            sel_op_s  = bus.req0_op;
        end
    end

    // Operand latch, settle timer, result capture and completion counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            settle_cnt_r <= 4'd0;
            div0_r       <= 1'b0;
            alu_opa_r    <= {DATA_W{1'b0}};
            alu_opb_r    <= {DATA_W{1'b0}};
            alu_op_r     <= 3'b000;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_data_r   <= 16'h0000;
            rsp_err_r    <= 1'b0;
            op_count_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                alu_opa_r    <= sel_opa_s;
                alu_opb_r    <= sel_opb_s;
                alu_op_r     <= sel_op_s;
                rsp_id_r     <= grant_s;
                last_grant_r <= grant_s;
                div0_r       <= (sel_op_s == OP_DIV) && (sel_opb_s == {DATA_W{1'b0}});
                settle_cnt_r <= SETTLE_INIT;
            end else if (state_r == EXEC && !capture_s) begin
                settle_cnt_r <= settle_cnt_r - 4'd1;
            end
            if (capture_s) begin
                rsp_data_r  <= div0_r ? 16'h0000 : bus.alu_result;
                rsp_err_r   <= div0_r;
                rsp_valid_r <= 1'b1;
            end else if (release_s) begin
                rsp_valid_r <= 1'b0;
                op_count_r  <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.req0_ready = accept_s & ~grant_s;
    assign bus.req1_ready = accept_s & grant_s;
    assign bus.alu_opa    = alu_opa_r;
    assign bus.alu_opb    = alu_opb_r;
    assign bus.alu_op     = alu_op_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = (state_r != IDLE);
    assign bus.op_count   = op_count_r;
endmodule
